// File: rtl/proj_slot_scheduler_pkg.sv
// rtl/proj_slot_scheduler_pkg.sv - shared constants and state type for the projectile slot scheduler
//
// Purpose: single source for slot ids, slot count, screen geometry and the
// scheduler state encoding. Shared by the scheduler and anything else that
// talks about projectile slots.
// Ports: none (package).
package proj_slot_scheduler_pkg;

   localparam int         NUM_PROJ           = 3;
   localparam logic [1:0] SLOT_NONE          = 2'd0;

   // Screen geometry; a slot at or above DEF_TOP_Y has left the play field.
   localparam int         SCREEN_H           = 480;
   localparam logic [8:0] DEF_TOP_Y          = 9'd4;

   localparam int         DEF_COOLDOWN_TICKS = 8;
   localparam int         DEF_CD_W           = 4;

   typedef enum logic {
      ST_READY    = 1'b0,
      ST_COOLDOWN = 1'b1
   } sched_state_t;

endpackage

// File: rtl/cooldown_timer.sv
// rtl/cooldown_timer.sv - loadable down-counter that counts movement ticks to zero
//
// Purpose: generic tick-based cooldown. Loaded with a value, counts down one
// per tick, holds at zero. Reusable for enemy fire-rate limiting.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset (count -> 0)
//   load      in  load load_val this cycle (wins over tick)
//   load_val  in  W-bit reload value
//   tick      in  1-cycle decrement strobe
//   done      out count is zero, or reaches zero at this edge
module cooldown_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         done
);

   logic [W-1:0] count;

   // done looks one edge ahead so the owner can leave cooldown on the same
   // edge that the counter lands on zero.
   assign done = (count == '0) || (tick && (count == W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/proj_slot_scheduler.sv
// rtl/proj_slot_scheduler.sv - allocates, moves and retires the three player projectile slots
//
// Purpose: turns fire-button edges into slot spawns (with cooldown), retires
// slots on enemy hit or on reaching the top of the screen, and gates the
// per-tick movement of the projectile datapath.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pulse_projSpeed   1-cycle movement tick
//   shoot             debounced fire button (level)
//   projHit           collision unit hit strobe
//   collidedProj      hit slot id 1..3, 0 = none
//   proj1Y..proj3Y    current Y of each slot
//   slot_active       bit i = slot i+1 in flight
//   spawn/spawn_slot  1-cycle spawn strobe and slot id (0 when idle)
//   move_en           1-cycle step strobe for every active slot
//   retire            1-cycle per-slot park strobe
//   ready             cooldown expired and a slot is free
//   shots_fired       saturating spawn count
module proj_slot_scheduler
   import proj_slot_scheduler_pkg::*;
#(
   parameter int         COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
   parameter logic [8:0] TOP_Y          = DEF_TOP_Y,
   parameter int         CD_W           = DEF_CD_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pulse_projSpeed,
   input  logic       shoot,
   input  logic       projHit,
   input  logic [1:0] collidedProj,
   input  logic [8:0] proj1Y,
   input  logic [8:0] proj2Y,
   input  logic [8:0] proj3Y,
   output logic [2:0] slot_active,
   output logic       spawn,
   output logic [1:0] spawn_slot,
   output logic       move_en,
   output logic [2:0] retire,
   output logic       ready,
   output logic [7:0] shots_fired
);

   sched_state_t state;
   logic         shoot_q;
   logic         req;
   logic         full;
   logic         fire;
   logic         cd_done;
   logic [1:0]   alloc_id;
   logic [2:0]   alloc_mask;
   logic [2:0]   hit_mask;
   logic [2:0]   top_mask;
   logic [2:0]   retire_mask;

   cooldown_timer #(.W(CD_W)) u_cooldown (
      .clk      (clk),
      .rst      (rst),
      .load     (fire),
      .load_val (CD_W'(COOLDOWN_TICKS)),
      .tick     (pulse_projSpeed),
      .done     (cd_done)
   );

   always_comb begin
      req  = shoot & ~shoot_q;
      full = &slot_active;

      // Lowest-index free slot, taken from the pre-edge occupancy so a slot
      // freed this cycle only becomes allocatable next cycle.
      alloc_id   = SLOT_NONE;
      alloc_mask = 3'b000;
      if (!slot_active[0]) begin
         alloc_id   = 2'd1;
         alloc_mask = 3'b001;
      end else if (!slot_active[1]) begin
         alloc_id   = 2'd2;
         alloc_mask = 3'b010;
      end else if (!slot_active[2]) begin
         alloc_id   = 2'd3;
         alloc_mask = 3'b100;
      end

      fire = (state == ST_READY) && req && !full;

      // Hits on inactive slots (including the one being spawned) are ignored.
      hit_mask = 3'b000;
      if (projHit && (collidedProj != SLOT_NONE)) begin
         hit_mask[collidedProj - 2'd1] = 1'b1;
      end
      hit_mask = hit_mask & slot_active;

      top_mask = {3{pulse_projSpeed}} & slot_active &
                 {(proj3Y <= TOP_Y), (proj2Y <= TOP_Y), (proj1Y <= TOP_Y)};

      // OR-merge so a simultaneous hit and top-retire yield one pulse.
      retire_mask = hit_mask | top_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_READY;
         shoot_q     <= 1'b0;
         slot_active <= 3'b000;
         spawn       <= 1'b0;
         spawn_slot  <= SLOT_NONE;
         move_en     <= 1'b0;
         retire      <= 3'b000;
         ready       <= 1'b0;
         shots_fired <= 8'd0;
      end else begin
         shoot_q     <= shoot;
         spawn       <= fire;
         spawn_slot  <= fire ? alloc_id : SLOT_NONE;
         slot_active <= (slot_active & ~retire_mask) | (fire ? alloc_mask : 3'b000);
         retire      <= retire_mask;
         // Uses pre-edge occupancy: a slot spawned on this tick is not moved.
         move_en     <= pulse_projSpeed && (|slot_active);
         ready       <= (state == ST_READY) && !full;

         if (fire && (shots_fired != 8'hFF)) begin
            shots_fired <= shots_fired + 8'd1;
         end

         case (state)
            ST_READY: begin
               // A zero cooldown never leaves READY: one shot per edge.
               if (fire && (COOLDOWN_TICKS != 0)) begin
                  state <= ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (cd_done) begin
                  state <= ST_READY;
               end
            end
            default: state <= ST_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_proj_slot_scheduler.sv
// tb/tb_proj_slot_scheduler.sv - randomized bench for proj_slot_scheduler against a behavioural model
module tb_proj_slot_scheduler;

   localparam int COOLDOWN = 8;
   localparam int TOPY     = 4;
   localparam int N_CYC    = 10000;
   localparam int RST_CYC  = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic       pulse_projSpeed;
   logic       shoot;
   logic       projHit;
   logic [1:0] collidedProj;
   logic [8:0] proj1Y, proj2Y, proj3Y;
   logic [2:0] slot_active;
   logic       spawn;
   logic [1:0] spawn_slot;
   logic       move_en;
   logic [2:0] retire;
   logic       ready;
   logic [7:0] shots_fired;

   proj_slot_scheduler #(
      .COOLDOWN_TICKS (COOLDOWN),
      .TOP_Y          (9'(TOPY)),
      .CD_W           (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pulse_projSpeed (pulse_projSpeed),
      .shoot           (shoot),
      .projHit         (projHit),
      .collidedProj    (collidedProj),
      .proj1Y          (proj1Y),
      .proj2Y          (proj2Y),
      .proj3Y          (proj3Y),
      .slot_active     (slot_active),
      .spawn           (spawn),
      .spawn_slot      (spawn_slot),
      .move_en         (move_en),
      .retire          (retire),
      .ready           (ready),
      .shots_fired     (shots_fired)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: slot occupancy as an array, cooldown as a tick count.
   bit m_act[3];
   bit m_cooling;
   int m_ticks_left;
   bit m_prev_shoot;
   bit m_spawn;
   int m_spawn_slot;
   bit m_move;
   bit m_ret[3];
   bit m_ready;
   int m_shots;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_act[i] = 1'b0;
         m_ret[i] = 1'b0;
      end
      m_cooling    = 1'b0;
      m_ticks_left = 0;
      m_prev_shoot = 1'b0;
      m_spawn      = 1'b0;
      m_spawn_slot = 0;
      m_move       = 1'b0;
      m_ready      = 1'b0;
      m_shots      = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit req;
      bit any;
      bit fire;
      int free_idx;
      int ys[3];
      ys[0] = int'(proj1Y);
      ys[1] = int'(proj2Y);
      ys[2] = int'(proj3Y);

      req      = shoot && !m_prev_shoot;
      any      = m_act[0] || m_act[1] || m_act[2];
      free_idx = -1;
      for (int i = 2; i >= 0; i--) if (!m_act[i]) free_idx = i;
      fire     = !m_cooling && req && (free_idx >= 0);

      m_ready = !m_cooling && (free_idx >= 0);
      m_move  = pulse_projSpeed && any;
      for (int k = 0; k < 3; k++) begin
         m_ret[k] = m_act[k] &&
                    ((projHit && (int'(collidedProj) == k + 1)) ||
                     (pulse_projSpeed && (ys[k] <= TOPY)));
      end
      for (int k = 0; k < 3; k++) if (m_ret[k]) m_act[k] = 1'b0;

      m_spawn      = fire;
      m_spawn_slot = fire ? free_idx + 1 : 0;
      if (fire) begin
         m_act[free_idx] = 1'b1;
         if (m_shots < 255) m_shots++;
      end

      if (fire) begin
         m_cooling    = (COOLDOWN != 0);
         m_ticks_left = COOLDOWN;
      end else if (m_cooling && pulse_projSpeed) begin
         m_ticks_left--;
         if (m_ticks_left == 0) m_cooling = 1'b0;
      end

      m_prev_shoot = shoot;
   endtask

   task automatic check_outputs();
      check_eq("slot_active", 32'(slot_active), 32'({m_act[2], m_act[1], m_act[0]}));
      check_eq("spawn", 32'(spawn), 32'(m_spawn));
      check_eq("spawn_slot", 32'(spawn_slot), 32'(m_spawn_slot));
      check_eq("move_en", 32'(move_en), 32'(m_move));
      check_eq("retire", 32'(retire), 32'({m_ret[2], m_ret[1], m_ret[0]}));
      check_eq("ready", 32'(ready), 32'(m_ready));
      check_eq("shots_fired", 32'(shots_fired), 32'(m_shots));
   endtask

   task automatic drive_random();
      pulse_projSpeed = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) shoot = ~shoot;
      projHit      = ($urandom_range(0, 7) == 0);
      collidedProj = 2'($urandom_range(0, 3));
      proj1Y       = 9'($urandom_range(0, 15));
      proj2Y       = 9'($urandom_range(0, 15));
      proj3Y       = 9'($urandom_range(0, 15));
   endtask

   initial begin
      rst             = 1'b1;
      pulse_projSpeed = 1'b0;
      shoot           = 1'b0;
      projHit         = 1'b0;
      collidedProj    = 2'd0;
      proj1Y          = 9'd100;
      proj2Y          = 9'd100;
      proj3Y          = 9'd100;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst = 1'b0;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         drive_random();
         model_step();
         @(negedge clk);
         check_outputs();
         if (cyc == RST_CYC) begin
            // Asynchronous reset mid-flight: outputs must clear before any edge.
            #2 rst = 1'b1;
            #1 model_reset();
            check_outputs();
            @(negedge clk);
            check_outputs();
            rst = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
